// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: FSM encoding, reset PC, entry layout.
// Build option: define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects instead of aligning them.
package fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FAULT = 3'd4
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef FETCH_MISALIGN_CHECK_EN
   localparam bit MISALIGN_CHECK_EN = 1'b1;
`else
   localparam bit MISALIGN_CHECK_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction FIFO: power-of-two ring buffer with an occupancy count and a flush.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;

   assign do_pop = pop && (count != '0);
   assign rdata  = mem[rd_ptr];

   // NOTE: only control state is reset; storage is qualified by count, so resetting it buys nothing.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: one-outstanding memory fetcher feeding a FIFO toward decode.
// Build option: FETCH_MISALIGN_CHECK_EN enables the FAULT state and the fetch_fault output.
module inst_fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state, state_nxt;
   logic [31:0]   fetch_pc, pc_nxt;
   logic          pend, pend_nxt;
   logic          push, pop;
   logic [CW-1:0] count;
   fetch_entry_t  wr_entry, head;
   logic [31:0]   redir_tgt;
   logic          redir_bad;
   logic          busy_after;

   assign redir_tgt = MISALIGN_CHECK_EN ? redirect_pc : align_pc(redirect_pc);
   assign redir_bad = MISALIGN_CHECK_EN && (redirect_pc[1:0] != 2'b00);

   // Will a granted access still be awaiting its response after this edge?
   assign busy_after = (state == ST_REQ && imem_gnt) ||
                       (((state == ST_WAIT) || (state == ST_DRAIN) ||
                         (state == ST_FAULT && pend)) && !imem_rvalid);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      pc_nxt    = fetch_pc;
      pend_nxt  = pend;
      push      = 1'b0;
      wr_entry  = '{pc: fetch_pc, data: imem_rdata};
      if (redirect_valid) begin
         pc_nxt   = redir_tgt;
         pend_nxt = 1'b0;
         if (redir_bad) begin
            state_nxt = ST_FAULT;
            pend_nxt  = busy_after;
         end else begin
            case (state)
               ST_IDLE:           state_nxt = ST_REQ;
               ST_REQ:            state_nxt = imem_gnt ? ST_DRAIN : ST_REQ;
               ST_WAIT, ST_DRAIN: state_nxt = imem_rvalid ? ST_IDLE : ST_DRAIN;
               ST_FAULT:          state_nxt = (pend && !imem_rvalid) ? ST_DRAIN : ST_REQ;
               default:           state_nxt = ST_IDLE;
            endcase
         end
      end else begin
         case (state)
            ST_IDLE:  if (count < CW'(DEPTH)) state_nxt = ST_REQ;
            ST_REQ:   if (imem_gnt) state_nxt = ST_WAIT;
            ST_WAIT: begin
               if (imem_rvalid) begin
                  push      = 1'b1;
                  pc_nxt    = fetch_pc + 32'd4;
                  state_nxt = ST_IDLE;
               end
            end
            ST_DRAIN: if (imem_rvalid) state_nxt = ST_IDLE;
            ST_FAULT: if (imem_rvalid) pend_nxt = 1'b0;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         pend     <= 1'b0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= pc_nxt;
         pend     <= pend_nxt;
      end
   end

   assign pop = inst_valid && inst_ready && !redirect_valid;

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (head),
      .count (count)
   );

   assign imem_req   = (state == ST_REQ);
   assign imem_addr  = fetch_pc;
   assign inst_valid = (count != '0);
   assign inst_data  = inst_valid ? head.data : 32'd0;
   assign inst_pc    = inst_valid ? head.pc   : 32'd0;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign fetch_fault = (state == ST_FAULT);
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised bench for inst_fetch_queue: memory responder plus a program-order reference model.
// Build option FETCH_MISALIGN_CHECK_EN selects the trapping-redirect expectations.
module tb_inst_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_fault    (fetch_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_checks = 0;
   int          n_fail   = 0;

   // Reference state: next program-order PC decode should see, plus one-deep memory model.
   logic [31:0] exp_pc;
   int          pops;
   int          grants;
   logic [31:0] last_pop_pc;
   bit          mem_busy;
   logic [31:0] mem_addr;
   int          mem_delay;
   int unsigned gnt_pct;
   int unsigned delay_lo, delay_hi;
   bit          gnt_seen;
   logic [31:0] first_gnt_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] model_redir(input logic [31:0] p);
`ifdef FETCH_MISALIGN_CHECK_EN
      return p;
`else
      return p & 32'hFFFF_FFFC;
`endif
   endfunction

   // One clock: drive inputs, predict the coming edge, then wait for the next falling edge.
   task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy);
      bit rv;
      bit busy_before;
      rv             = mem_busy && (mem_delay == 0);
      busy_before    = mem_busy;
      imem_gnt       = ($urandom_range(99) < gnt_pct);
      imem_rvalid    = rv;
      imem_rdata     = rv ? mem_fn(mem_addr) : $urandom;
      redirect_valid = redir;
      redirect_pc    = rpc;
      inst_ready     = rdy;
      #1;
      if (inst_valid && rdy && !redir) begin
         check("pop_pc", inst_pc, exp_pc);
         check("pop_data", inst_data, mem_fn(exp_pc));
         last_pop_pc = inst_pc;
         exp_pc      = exp_pc + 32'd4;
         pops++;
      end
      if (redir) exp_pc = model_redir(rpc);
      if (rv) mem_busy = 1'b0;
      else if (mem_busy) mem_delay--;
      if (imem_req && imem_gnt) begin
         check("one_outstanding", {31'd0, busy_before}, 32'd0);
         check("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
         mem_busy  = 1'b1;
         mem_addr  = imem_addr;
         mem_delay = int'($urandom_range(delay_hi, delay_lo));
         grants++;
         if (!gnt_seen) begin
            gnt_seen       = 1'b1;
            first_gnt_addr = imem_addr;
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_pops(input int n, input int budget);
      int target;
      int k;
      target = pops + n;
      k      = 0;
      while (pops < target && k < budget) begin
         cycle(1'b0, 32'd0, 1'b1);
         k++;
      end
      check("pop_timeout", {31'd0, pops >= target}, 32'd1);
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      #1;
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
      mem_busy = 1'b0;
      exp_pc   = RESET_PC;
      grants   = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int k;
      int pops_start;
      rst            = 1'b1;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'd0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      pops           = 0;
      gnt_seen       = 1'b0;
      gnt_pct        = 100;
      delay_lo       = 0;
      delay_hi       = 0;
      #2;
      do_reset();

      // Sequential fetch with an ideal memory.
      for (int i = 0; i < 40; i++) cycle(1'b0, 32'd0, 1'b1);
      check("seq_progress", {31'd0, pops >= 10}, 32'd1);

      // Decode stalled: exactly DEPTH fetches, then no request while full.
      do_reset();
      for (int i = 0; i < 30; i++) cycle(1'b0, 32'd0, 1'b0);
      check("full_grants", grants, DEPTH);
      check("full_no_req", {31'd0, imem_req}, 32'd0);
      check("full_valid", {31'd0, inst_valid}, 32'd1);
      gnt_seen = 1'b0;
      k = 0;
      while (!gnt_seen && k < 20) begin
         cycle(1'b0, 32'd0, 1'b1);
         k++;
      end
      check("resume_addr", first_gnt_addr, 32'h10);
      wait_pops(6, 60);

      // Best-case redirect latency from an idle, empty queue.
      do_reset();
      cycle(1'b1, 32'h40, 1'b0);
      check("lat_req", {31'd0, imem_req}, 32'd1);
      check("lat_addr", imem_addr, 32'h40);
      cycle(1'b0, 32'd0, 1'b0);
      check("lat_n2_valid", {31'd0, inst_valid}, 32'd0);
      cycle(1'b0, 32'd0, 1'b0);
      check("lat_n3_valid", {31'd0, inst_valid}, 32'd1);
      check("lat_n3_pc", inst_pc, 32'h40);

      // Redirect while waiting for data: the late response must be dropped.
      delay_lo = 3;
      delay_hi = 3;
      k = 0;
      while (!(mem_busy && mem_delay == 3) && k < 50) begin
         cycle(1'b0, 32'd0, 1'b1);
         k++;
      end
      check("wait_state_reached", {31'd0, mem_busy}, 32'd1);
      cycle(1'b1, 32'h100, 1'b1);
      wait_pops(1, 60);
      check("redir_wait_pc", last_pop_pc, 32'h100);

      // Redirect coinciding with a response and a pop.
      delay_lo = 0;
      delay_hi = 0;
      k = 0;
      while (!(inst_valid && mem_busy && mem_delay == 0) && k < 40) begin
         cycle(1'b0, 32'd0, 1'b0);
         k++;
      end
      check("collide_setup", {31'd0, inst_valid && mem_busy}, 32'd1);
      cycle(1'b1, 32'h300, 1'b1);
      check("collide_flush", {31'd0, inst_valid}, 32'd0);
      wait_pops(1, 40);
      check("collide_pc", last_pop_pc, 32'h300);

      // PC wrap at the top of the address space.
      cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
      wait_pops(2, 40);
      check("wrap_pc", last_pop_pc, 32'h0);

      // Misaligned redirect.
      cycle(1'b1, 32'h102, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("fault_set", {31'd0, fetch_fault}, 32'd1);
      check("fault_no_req", {31'd0, imem_req}, 32'd0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b1);
      check("fault_hold", {31'd0, fetch_fault}, 32'd1);
      check("fault_hold_req", {31'd0, imem_req}, 32'd0);
      check("fault_empty", {31'd0, inst_valid}, 32'd0);
      cycle(1'b1, 32'h200, 1'b1);
      check("fault_clear", {31'd0, fetch_fault}, 32'd0);
      wait_pops(1, 40);
      check("fault_exit_pc", last_pop_pc, 32'h200);
`else
      check("misalign_no_fault", {31'd0, fetch_fault}, 32'd0);
      wait_pops(1, 40);
      check("misalign_forced_pc", last_pop_pc, 32'h100);
`endif

      // Randomised traffic against the reference model.
      gnt_pct    = 60;
      delay_lo   = 0;
      delay_hi   = 3;
      pops_start = pops;
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] r;
         bit          rd;
         r = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
         r[1:0] = 2'b00;
`endif
         rd = ($urandom_range(99) < 4);
         cycle(rd, r, 1'($urandom_range(1)));
      end
      check("random_progress", {31'd0, (pops - pops_start) > 100}, 32'd1);

      // Asynchronous reset in the middle of an access, then stale responses after release.
      gnt_pct  = 100;
      delay_lo = 3;
      delay_hi = 3;
      k = 0;
      while (!(inst_valid && mem_busy && mem_delay == 3) && k < 60) begin
         cycle(1'b0, 32'd0, 1'b0);
         k++;
      end
      check("async_setup", {31'd0, inst_valid}, 32'd1);
      do_reset();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("stale_ignored", {31'd0, inst_valid}, 32'd0);
      delay_lo = 0;
      delay_hi = 0;
      wait_pops(2, 40);
      check("post_reset_pc", last_pop_pc, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
